rr_mux2_arbiter: RTL and testbench
==================================

# rr_mux2_arbiter

Two-channel round-robin arbiter that sits directly upstream of the `mux2to1` data select. It accepts two valid/ready input streams and produces the select that steers the 2:1 data path. The selected word is held in a registered output stage with a valid/ready handshake. Grants are burst-limited so neither channel can starve the other.

## Interface
- `WIDTH`, default 8: data width per channel.
- `BURST_LEN`, default 4, legal range ≥1: maximum consecutive beats one channel may win while the other channel is requesting.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `in0_valid` input 1: channel 0 has a word.
- `in0_data` input WIDTH: channel 0 word.
- `in0_ready` output 1: channel 0 word is accepted this cycle.
- `in1_valid`, `in1_data`, `in1_ready`: same as the channel 0 signals, for channel 1.
- `out_valid` output 1: the output register holds a word.
- `out_data` output WIDTH: the registered selected word.
- `out_sel` output 1: the channel that supplied `out_data`.
- `out_ready` input 1: the downstream stage accepts `out_data`.

## Operation
- `load = !out_valid || out_ready`. The output register can take a new word only when `load` is high.
- Grant state `st` is one of IDLE, G0 or G1.
  - `cnt` counts beats in the current grant, 0..BURST_LEN.
  - `prio` is the preferred channel when in IDLE.
- Winner `w`, combinational, evaluated only when `load=1`:
  - In IDLE:
    - Both channels valid: `w = prio`.
    - Only one channel valid: `w` is that channel.
  - In Gi:
    - `in_valid_i` and `cnt < BURST_LEN`: `w = i`.
    - Otherwise, if the other channel is valid: `w` is the other channel.
    - Otherwise, if `in_valid_i`: `w = i` and the burst restarts.
- `inX_ready = load && (w == X) && inX_valid`. At most one ready is high per cycle.
- Transfer: on a clock edge where `inX_ready` is high:
  - `out_data` is loaded with `inX_data`, via a generate of WIDTH `mux2to1` instances with select `w`.
  - `out_sel` is set to `w` and `out_valid` to 1.
  - `st` moves to Gw and `prio` to `~w`.
  - `cnt` becomes `cnt+1` if `w` equals the previous grant and the burst did not restart; otherwise `cnt` becomes 1.
- `load=1` with no input valid:
  - `out_valid` goes to 0 if `out_ready` was high.
  - `st` returns to IDLE and `cnt` to 0. `prio` is unchanged.
- `load=0` (downstream stall): `out_data`, `out_sel`, `out_valid`, `st`, `cnt` and `prio` all hold. Both readies are 0.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_sel=0`, `st=IDLE`, `cnt=0`, `prio=0` (channel 0 preferred).
- Reset with `rst_n` low overrides any in-flight transfer on that edge.
  - No input is accepted on that edge.
  - A word held in the output register is discarded.
- Latency: a word accepted at edge N appears on `out_data` with `out_valid=1` immediately after edge N.
- Throughput: one word per cycle while `out_ready` stays high.
- Readies depend combinationally on the valids, `out_ready` and state. Nothing depends combinationally on `in*_data`.
- With both channels continuously valid, the grant sequence is BURST_LEN beats of one channel, then BURST_LEN of the other, repeating.
- With BURST_LEN=1 the grant strictly alternates.
- Simultaneous `out_ready` and a new input in the same cycle: the old word drains and the new word loads on the same edge, with no bubble.

## Structure
- A shared package `mux_pkg` holds:
  - the state encoding: IDLE=2'd0, G0=2'd1, G1=2'd2;
  - the `cnt` width, `$clog2(BURST_LEN+1)` with a minimum of 1.
- Sub-module: the existing `mux2to1`, instanced per data bit in a generate loop. There are no other sub-modules.

## Test plan
- Reset: hold `rst_n=0` for 3 cycles with both valids high → both readies 0, `out_valid=0`, `out_data=0`. First release edge with both valid → `out_sel=0` (prio 0 wins).
- Single stream: `in0` sends 0x11, 0x22, 0x33 with `out_ready=1` and `in1` idle → outputs 0x11, 0x22, 0x33 on consecutive cycles, `out_sel=0`, no bubbles, burst restarts after 4.
- Contention with BURST_LEN=2: both channels always valid (`in0=0xA*`, `in1=0xB*`) → `out_sel` sequence 0,0,1,1,0,0,…
- Backpressure: drop `out_ready` for 3 cycles while holding 0x5A → `out_data=0x5A` stable, both readies 0, `cnt` unchanged. On release, the next word follows on the next edge.
- Mid-burst reset: assert `rst_n=0` during the 2nd beat of a G1 burst → the next cycle shows `out_valid=0`, and the next contention grants channel 0.
- Idle return: both valids drop after 0x77 from `in1` → `out_valid` falls after it drains and `st=IDLE`. A later simultaneous request grants channel 0, because `prio=~1=0`.

Source files
------------

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared grant-state encoding and counter sizing for the 2:1 select arbiter
package mux_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G0   = 2'd1,
      G1   = 2'd2
   } st_t;

   // Beat counter must hold 0..burst_len inclusive.
   function automatic int cnt_width(input int burst_len);
      int w;
      w = $clog2(burst_len + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/mux2to1.sv
// rtl/mux2to1.sv - single-bit 2:1 data select
module mux2to1 (
   input  logic a,
   input  logic b,
   input  logic sel,
   output logic y
);

   assign y = sel ? b : a;

endmodule

// File: rtl/rr_mux2_arbiter.sv
// rtl/rr_mux2_arbiter.sv - burst-limited round-robin arbiter driving a registered 2:1 select
module rr_mux2_arbiter
   import mux_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int BURST_LEN = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in0_valid,
   input  logic [WIDTH-1:0] in0_data,
   output logic             in0_ready,
   input  logic             in1_valid,
   input  logic [WIDTH-1:0] in1_data,
   output logic             in1_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_sel,
   input  logic             out_ready
);

   localparam int CW = cnt_width(BURST_LEN);
   localparam logic [CW-1:0] BL = CW'(BURST_LEN);

   st_t             st;
   logic [CW-1:0]   cnt;
   logic            prio;

   logic            load;
   logic            win;
   logic            w;
   logic            restart;
   logic            g;
   logic            vg;
   logic            vo;
   logic [WIDTH-1:0] mux_y;

   assign load = !out_valid || out_ready;
   assign g    = (st == G1);
   assign vg   = g ? in1_valid : in0_valid;
   assign vo   = g ? in0_valid : in1_valid;

   always_comb begin
      win     = 1'b0;
      w       = 1'b0;
      restart = 1'b0;
      if (load) begin
         if (st == IDLE) begin
            if (in0_valid && in1_valid) begin
               win = 1'b1;
               w   = prio;
            end else if (in0_valid || in1_valid) begin
               win = 1'b1;
               w   = in1_valid;
            end
         end else if (vg && (cnt < BL)) begin
            win = 1'b1;
            w   = g;
         end else if (vo) begin
            win = 1'b1;
            w   = ~g;
         end else if (vg) begin
            // Lone requester keeps the grant but starts a fresh burst.
            win     = 1'b1;
            w       = g;
            restart = 1'b1;
         end
      end
   end

   // Reset gates the readies so nothing is accepted on a reset edge.
   assign in0_ready = rst_n && win && !w;
   assign in1_ready = rst_n && win && w;

   for (genvar i = 0; i < WIDTH; i++) begin : g_mux
      mux2to1 u_mux (
         .a   (in0_data[i]),
         .b   (in1_data[i]),
         .sel (w),
         .y   (mux_y[i])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= 1'b0;
         st        <= IDLE;
         cnt       <= '0;
         prio      <= 1'b0;
      end else if (load) begin
         if (win) begin
            out_valid <= 1'b1;
            out_data  <= mux_y;
            out_sel   <= w;
            st        <= w ? G1 : G0;
            prio      <= ~w;
            if ((st == (w ? G1 : G0)) && !restart)
               cnt <= cnt + CW'(1);
            else
               cnt <= CW'(1);
         end else begin
            out_valid <= 1'b0;
            st        <= IDLE;
            cnt       <= '0;
         end
      end
   end

endmodule

// File: tb/tb_rr_mux2_arbiter.sv
// tb/tb_rr_mux2_arbiter.sv - directed scoreboard bench for rr_mux2_arbiter
module tb_rr_mux2_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in0_valid = 1'b0;
   logic [7:0] in0_data = '0;
   logic       in0_ready;
   logic       in1_valid = 1'b0;
   logic [7:0] in1_data = '0;
   logic       in1_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_sel;
   logic       out_ready = 1'b0;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic       sel;
      logic [7:0] data;
   } exp_t;

   exp_t       sb[$];
   exp_t       e;
   logic       last_sel  = 1'b0;
   logic [7:0] last_data = '0;

   rr_mux2_arbiter #(.WIDTH(8), .BURST_LEN(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in0_valid (in0_valid),
      .in0_data  (in0_data),
      .in0_ready (in0_ready),
      .in1_valid (in1_valid),
      .in1_data  (in1_data),
      .in1_ready (in1_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One directed beat: exp_w is the channel that must win (-1 for none),
   // exp_ov the out_valid expected after the edge.
   task automatic step(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1,
                       input logic ordy, input int exp_w, input logic exp_ov, input string tag);
      in0_valid = v0; in0_data = d0;
      in1_valid = v1; in1_data = d1;
      out_ready = ordy;
      #2;
      chk({tag, ".in0_ready"}, {31'd0, in0_ready}, {31'd0, exp_w == 0});
      chk({tag, ".in1_ready"}, {31'd0, in1_ready}, {31'd0, exp_w == 1});
      if (exp_w >= 0) sb.push_back(exp_t'{sel: (exp_w == 1), data: (exp_w == 1) ? d1 : d0});
      @(posedge clk);
      #1;
      chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, exp_ov});
      if (exp_w >= 0) begin
         if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd0, 32'd1);
         end else begin
            e = sb.pop_front();
            chk({tag, ".out_data"}, {24'd0, out_data}, {24'd0, e.data});
            chk({tag, ".out_sel"}, {31'd0, out_sel}, {31'd0, e.sel});
            last_data = e.data;
            last_sel  = e.sel;
         end
      end else if (exp_ov) begin
         chk({tag, ".hold_data"}, {24'd0, out_data}, {24'd0, last_data});
         chk({tag, ".hold_sel"}, {31'd0, out_sel}, {31'd0, last_sel});
      end
   endtask

   task automatic reset_cycle(input string tag);
      rst_n = 1'b0;
      in0_valid = 1'b1; in1_valid = 1'b1;
      in0_data = 8'hE0; in1_data = 8'hE1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, ".in0_ready"}, {31'd0, in0_ready}, 32'd0);
      chk({tag, ".in1_ready"}, {31'd0, in1_ready}, 32'd0);
      chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, ".out_data"}, {24'd0, out_data}, 32'd0);
      chk({tag, ".out_sel"}, {31'd0, out_sel}, 32'd0);
      sb.delete();
   endtask

   initial begin
      // Reset held for three cycles with both channels requesting.
      for (int i = 0; i < 3; i++) reset_cycle("reset");
      rst_n = 1'b1;
      step(1'b1, 8'hA0, 1'b1, 8'hB0, 1'b1, 0, 1'b1, "rel_prio0");

      // Single stream on channel 0: no bubbles, bursts restart with a lone requester.
      step(1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 0, 1'b1, "single0");
      step(1'b1, 8'h22, 1'b0, 8'h00, 1'b1, 0, 1'b1, "single1");
      step(1'b1, 8'h33, 1'b0, 8'h00, 1'b1, 0, 1'b1, "single2");
      step(1'b1, 8'h44, 1'b0, 8'h00, 1'b1, 0, 1'b1, "single3");
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, -1, 1'b0, "drain");

      // Contention from IDLE; last winner was 0, so channel 1 is preferred.
      step(1'b1, 8'hA1, 1'b1, 8'hB1, 1'b1, 1, 1'b1, "cont0");
      step(1'b1, 8'hA2, 1'b1, 8'hB2, 1'b1, 1, 1'b1, "cont1");
      step(1'b1, 8'hA3, 1'b1, 8'hB3, 1'b1, 0, 1'b1, "cont2");
      step(1'b1, 8'hA4, 1'b1, 8'hB4, 1'b1, 0, 1'b1, "cont3");
      step(1'b1, 8'hA5, 1'b1, 8'hB5, 1'b1, 1, 1'b1, "cont4");
      step(1'b1, 8'hA6, 1'b1, 8'hB6, 1'b1, 1, 1'b1, "cont5");

      // Backpressure: 0x5A held for three stalled cycles, grant count frozen.
      step(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 0, 1'b1, "bp_load");
      for (int i = 0; i < 3; i++)
         step(1'b1, 8'h5C, 1'b1, 8'hBC, 1'b0, -1, 1'b1, "bp_stall");
      step(1'b1, 8'h5C, 1'b1, 8'hBC, 1'b1, 0, 1'b1, "bp_rel0");
      step(1'b1, 8'h5D, 1'b1, 8'hBD, 1'b1, 1, 1'b1, "bp_rel1");

      // Reset during the second beat of a channel-1 burst.
      reset_cycle("midrst");
      rst_n = 1'b1;
      step(1'b1, 8'hA7, 1'b1, 8'hB7, 1'b1, 0, 1'b1, "midrst_cont");

      // Idle return after 0x77 from channel 1, then priority back to channel 0.
      step(1'b0, 8'h00, 1'b1, 8'h77, 1'b1, 1, 1'b1, "idle_77");
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, -1, 1'b0, "idle_drain");
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, -1, 1'b0, "idle_quiet");
      step(1'b1, 8'hA8, 1'b1, 8'hB8, 1'b1, 0, 1'b1, "idle_prio");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
